// File: rtl/freq_div_ctrl_pkg.sv
// Shared definitions for the programmable clock-divider controller.
// State encoding and the smallest legal divide ratio.
package freq_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_mod_counter.sv
// Mod-N up-counter with synchronous clear and a registered wrap pulse.
// Exposes its next count so the owner can register decoded outputs in step with it.
module div_mod_counter
    import freq_div_ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    input  logic [W-1:0] mod,
    output logic [W-1:0] cnt_next,
    output logic         wrap
);

    logic [W-1:0] cnt;
    logic [W-1:0] last;

    assign last = mod - W'(1);

    always_comb begin
        cnt_next = cnt;
        if (clear) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = (cnt == last) ? '0 : cnt + W'(1);
        end
    end

    // wrap is high in exactly the cycle where cnt == mod-1; mod only changes
    // when the count restarts at 0, so comparing against the current mod is safe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            wrap <= inc && !clear && (cnt_next == last);
        end
    end

endmodule

// File: rtl/freq_div_ctrl.sv
// Programmable integer clock-divider controller: FSM, ratio handshake and output decode.
// Optional completed-period counter enabled by defining FREQ_DIV_CTRL_PCNT_EN.
module freq_div_ctrl
    import freq_div_ctrl_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic [W-1:0] cur_div,
    output logic         busy,
    output logic         tick,
    output logic         div_out,
    output logic [1:0]   dbg_state
`ifdef FREQ_DIV_CTRL_PCNT_EN
    ,
    output logic [15:0]  period_cnt
`endif
);

    // Handshake: a ratio transfers on any cycle with cfg_valid && cfg_ready;
    // cfg_ready depends only on state, never on cfg_valid.

    state_t       state, state_n;
    logic [W-1:0] pend_div, pend_n, cur_n;
    logic         err_n, tick_n, div_n;
    logic         xfer, bad;
    logic [W-1:0] cnt_next;
    logic         wrap;

    assign cfg_ready = (state != PEND);
    assign busy      = (state != IDLE);
    assign dbg_state = state;
    assign xfer      = cfg_valid && cfg_ready;
    assign bad       = (cfg_div < W'(MIN_DIV));

    div_mod_counter #(.W(W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .inc      (state != IDLE),
        .mod      (cur_div),
        .cnt_next (cnt_next),
        .wrap     (wrap)
    );

    always_comb begin
        state_n = state;
        cur_n   = cur_div;
        pend_n  = pend_div;
        err_n   = xfer && bad;
        case (state)
            IDLE: begin
                if (xfer && !bad) cur_n = cfg_div;
                if (en) state_n = RUN;
            end
            RUN: begin
                if (wrap && !en) begin
                    state_n = IDLE;
                    if (xfer && !bad) cur_n = cfg_div;
                end else if (xfer && !bad) begin
                    pend_n  = cfg_div;
                    state_n = PEND;
                end
            end
            PEND: begin
                if (wrap) begin
                    cur_n   = pend_div;
                    pend_n  = '0;
                    state_n = en ? RUN : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // High phase is ceil(N/2) cycles, measured with the ratio of the coming cycle.
        tick_n = (state_n != IDLE) && (cnt_next == '0);
        div_n  = (state_n != IDLE) && (cnt_next < (cur_n - (cur_n >> 1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cur_div  <= W'(DEFAULT_DIV);
            pend_div <= '0;
            cfg_err  <= 1'b0;
            tick     <= 1'b0;
            div_out  <= 1'b0;
        end else begin
            state    <= state_n;
            cur_div  <= cur_n;
            pend_div <= pend_n;
            cfg_err  <= err_n;
            tick     <= tick_n;
            div_out  <= div_n;
        end
    end

`ifdef FREQ_DIV_CTRL_PCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt <= '0;
        end else if (wrap && period_cnt != 16'hFFFF) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`else
    // Without the period counter the wrap strobe only steers the FSM.
`endif

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Self-checking bench for freq_div_ctrl: cycle model feeds an expected queue,
// directed scenarios plus a random phase; define FREQ_DIV_CTRL_PCNT_EN to check period_cnt.
module tb_freq_div_ctrl;

    localparam int W   = 8;
    localparam int DEF = 4;
    localparam int EW  = 7 + W + 16;

    logic         clk = 1'b0;
    logic         reset, en, cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready, cfg_err, busy, tick, div_out;
    logic [W-1:0] cur_div;
    logic [1:0]   dbg_state;
`ifdef FREQ_DIV_CTRL_PCNT_EN
    logic [15:0]  period_cnt;
`endif

    freq_div_ctrl #(.W(W), .DEFAULT_DIV(DEF)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .cur_div   (cur_div),
        .busy      (busy),
        .tick      (tick),
        .div_out   (div_out),
        .dbg_state (dbg_state)
`ifdef FREQ_DIV_CTRL_PCNT_EN
        ,
        .period_cnt(period_cnt)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // reference model of the controller, advanced once per clock edge
    int   m_state, m_cnt, m_cur, m_pend, m_pcnt;
    logic m_err;

    task automatic model_update();
        bit xfer, good;
        xfer = cfg_valid && (m_state != 2);
        good = xfer && (cfg_div >= 2);
        if (reset) begin
            m_state = 0; m_cnt = 0; m_cur = DEF; m_pend = 0; m_err = 1'b0; m_pcnt = 0;
            return;
        end
        m_err = xfer && !good;
        if (m_state == 0) begin
            if (good) m_cur = cfg_div;
            if (en) begin
                m_state = 1;
                m_cnt   = 0;
            end
        end else if (m_cnt == m_cur - 1) begin
            m_cnt = 0;
            if (m_pcnt < 65535) m_pcnt++;
            if (m_state == 2) begin
                m_cur   = m_pend;
                m_state = en ? 1 : 0;
            end else if (!en) begin
                m_state = 0;
                if (good) m_cur = cfg_div;
            end else if (good) begin
                m_pend  = cfg_div;
                m_state = 2;
            end
        end else begin
            m_cnt++;
            if (good) begin
                m_pend  = cfg_div;
                m_state = 2;
            end
        end
    endtask

    // driver: advance model, push expectation, clock, pop and compare
    task automatic step();
        logic         e_busy, e_ready, e_err, e_tick, e_div;
        logic [1:0]   e_state;
        logic [W-1:0] e_cur;
        logic [15:0]  e_pcnt;
        model_update();
        e_busy = (m_state != 0);
        exp_q.push_back({e_busy, 1'(m_state != 2), m_err, 1'(e_busy && m_cnt == 0),
                         1'(e_busy && (m_cnt < m_cur - m_cur / 2)), 2'(m_state),
                         W'(m_cur), 16'(m_pcnt)});
        @(posedge clk);
        #1;
        {e_busy, e_ready, e_err, e_tick, e_div, e_state, e_cur, e_pcnt} = exp_q.pop_front();
        check("busy",      busy,      e_busy);
        check("cfg_ready", cfg_ready, e_ready);
        check("cfg_err",   cfg_err,   e_err);
        check("tick",      tick,      e_tick);
        check("div_out",   div_out,   e_div);
        check("state",     dbg_state, e_state);
        check("cur_div",   cur_div,   e_cur);
`ifdef FREQ_DIV_CTRL_PCNT_EN
        check("period_cnt", period_cnt, e_pcnt);
`endif
    endtask

    task automatic stop_wait(input int lim);
        en = 1'b0;
        for (int i = 0; i < lim && busy === 1'b1; i++) step();
        check("stop_busy", busy, 0);
        check("stop_div", div_out, 0);
    endtask

    task automatic load_ratio(input int n);
        cfg_valid = 1'b1;
        cfg_div   = W'(n);
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        step();
        step();
        check("rst_cur", cur_div, DEF);
        check("rst_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_tick", tick, 0);
        reset = 1'b0;

        // default ratio 4: tick at 1,5,9, div_out 1,1,0,0
        en = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            check("t1_tick", tick, 32'((i % 4) == 0));
            check("t1_div", div_out, 32'((i % 4) < 2));
            step();
        end
        stop_wait(10);

        // ratio 3 loaded while idle
        load_ratio(3);
        check("t2_cur", cur_div, 3);
        en = 1'b1;
        step();
        for (int i = 0; i < 9; i++) begin
            check("t2_tick", tick, 32'((i % 3) == 0));
            check("t2_div", div_out, 32'((i % 3) < 2));
            step();
        end
        stop_wait(10);

        // running N=4, ratio 2 offered at cnt=1, applied at the wrap
        load_ratio(4);
        en = 1'b1;
        step();
        step();
        check("t3_ready_pre", cfg_ready, 1);
        cfg_valid = 1'b1; cfg_div = W'(2);
        step();
        cfg_valid = 1'b0;
        check("t3_ready_pend", cfg_ready, 0);
        check("t3_cur_hold", cur_div, 4);
        step();
        check("t3_ready_last", cfg_ready, 0);
        check("t3_div_last", div_out, 0);
        step();
        check("t3_cur_new", cur_div, 2);
        check("t3_ready_back", cfg_ready, 1);
        for (int i = 0; i < 6; i++) begin
            check("t3_tick", tick, 32'((i % 2) == 0));
            check("t3_div", div_out, 32'((i % 2) == 0));
            step();
        end

        // rejected ratios 1 and 0
        load_ratio(1);
        check("t4_err1", cfg_err, 1);
        check("t4_cur1", cur_div, 2);
        step();
        check("t4_err1_end", cfg_err, 0);
        load_ratio(0);
        check("t4_err0", cfg_err, 1);
        step();
        check("t4_err0_end", cfg_err, 0);
        check("t4_cur0", cur_div, 2);
        stop_wait(10);

        // N=5, en dropped at cnt=2: period completes
        load_ratio(5);
        en = 1'b1;
        step(); step(); step();
        en = 1'b0;
        step();
        check("t5_busy_c3", busy, 1);
        step();
        check("t5_busy_c4", busy, 1);
        step();
        check("t5_idle", busy, 0);
        check("t5_div", div_out, 0);
        // en re-raised at cnt=3: seamless
        en = 1'b1;
        step(); step(); step();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        check("t5_notick", tick, 0);
        step();
        check("t5_tick", tick, 1);
        check("t5_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            check("t5_cad_div", div_out, 32'(i < 3));
            step();
        end
        stop_wait(10);

        // reset while PEND at cnt=2 drops the pending ratio
        en = 1'b1;
        step(); step();
        cfg_valid = 1'b1; cfg_div = W'(3);
        step();
        cfg_valid = 1'b0;
        check("t6_pend", dbg_state, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_cur", cur_div, DEF);
        check("t6_busy", busy, 0);
        check("t6_div", div_out, 0);
        check("t6_ready", cfg_ready, 1);
`ifdef FREQ_DIV_CTRL_PCNT_EN
        check("t6_pcnt0", period_cnt, 0);
`endif
        step();
        check("t6_restart_tick", tick, 1);
        for (int i = 0; i < 12; i++) step();
        check("t6_cur_after", cur_div, DEF);
`ifdef FREQ_DIV_CTRL_PCNT_EN
        check("t6_pcnt3", period_cnt, 3);
`endif
        stop_wait(10);

        // largest ratio
        load_ratio(255);
        en = 1'b1;
        step();
        for (int i = 0; i < 255; i++) step();
        check("t7_tick", tick, 1);
        check("t7_cur", cur_div, 255);
        stop_wait(300);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = W'($urandom_range(0, 7));
            reset     = ($urandom_range(0, 150) == 0);
            step();
        end
        reset = 1'b0; cfg_valid = 1'b0;
        stop_wait(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
